// File: rtl/midi_pkg.sv
// Shared MIDI constants, receiver state encoding and status decode helper
// for the note decoder and its serial receiver.
package midi_pkg;

  localparam logic [3:0] STATUS_NOTE_OFF      = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON       = 4'h9;
  localparam logic [3:0] STATUS_PROG_CHANGE   = 4'hC;
  localparam logic [3:0] STATUS_CHAN_PRESSURE = 4'hD;

  localparam logic [7:0] REALTIME_MIN  = 8'hF8;
  localparam logic [7:0] SYSCOMMON_MIN = 8'hF0;

  typedef enum logic [2:0] {
    RX_WAIT_IDLE = 3'd0,
    RX_IDLE      = 3'd1,
    RX_START     = 3'd2,
    RX_DATA      = 3'd3,
    RX_STOP      = 3'd4
  } rx_state_t;

  // Channel messages carrying a single data byte; every other one carries two.
  function automatic logic one_data_byte(input logic [3:0] kind);
    return (kind == STATUS_PROG_CHANGE) || (kind == STATUS_CHAN_PRESSURE);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: two-flop synchroniser, mid-bit sampling state machine,
// one-cycle byte_valid on a good stop bit and framing_err on a bad one.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int BIT_CYCLES = 768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_t       state;
  rx_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_next;
  logic [7:0]      shift;
  logic [7:0]      shift_next;
  logic [7:0]      data_next;
  logic            valid_next;
  logic            ferr_next;

  // Synchroniser, state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      state       <= RX_WAIT_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      data        <= 8'h00;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      data        <= data_next;
      byte_valid  <= valid_next;
      framing_err <= ferr_next;
    end
  end

  // Next-state logic; the counter is reused as idle, half-bit and bit timer.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    data_next    = data;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    case (state)
      RX_WAIT_IDLE: begin
        if (!rx_sync) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = RX_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_sync) begin
          state_next = RX_START;
        end else begin
          state_next = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          if (!rx_sync) begin
            state_next   = RX_DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = RX_IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_sync) begin
            state_next = RX_IDLE;
            data_next  = shift;
            valid_next = 1'b1;
          end else begin
            state_next = RX_WAIT_IDLE;
            ferr_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RX_WAIT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI channel-voice parser: monophonic last-note-priority note/velocity/gate
// with a changeCLK strobe one cycle after every note-on update.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 31250,
  parameter int BIT_CYCLES = CLK_HZ / BAUD,
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 0
) (
  input  logic       CLK24M,
  input  logic       RST,
  input  logic       midi_rx,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       changeCLK,
  output logic       framing_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [7:0] status;
  logic       status_valid;
  logic       data_idx;
  logic [6:0] first_data;
  logic       change_pending;
  logic [3:0] kind;
  logic       chan_match;
  logic       note_on_hit;
  logic       note_off_hit;

  midi_uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk         (CLK24M),
    .rst         (RST),
    .rx          (midi_rx),
    .data        (rx_byte),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  assign kind        = status[7:4];
  assign chan_match  = (OMNI != 0) || (status[3:0] == 4'(CHANNEL));
  assign note_on_hit = chan_match && (kind == STATUS_NOTE_ON) && (rx_byte[6:0] != 7'd0);
  // Note-on with velocity 0 is a note-off; only the sounding key releases the gate.
  assign note_off_hit = chan_match && ((kind == STATUS_NOTE_OFF) || (kind == STATUS_NOTE_ON))
                        && (first_data == note) && gate;

  // Running-status parser and note outputs.
  always_ff @(posedge CLK24M) begin
    if (RST) begin
      status         <= 8'h00;
      status_valid   <= 1'b0;
      data_idx       <= 1'b0;
      first_data     <= 7'd0;
      note           <= 7'd0;
      velocity       <= 7'd0;
      gate           <= 1'b0;
      change_pending <= 1'b0;
      changeCLK      <= 1'b0;
    end else begin
      change_pending <= 1'b0;
      changeCLK      <= change_pending;
      if (byte_valid && (rx_byte < REALTIME_MIN)) begin
        if (rx_byte >= SYSCOMMON_MIN) begin
          status_valid <= 1'b0;
          data_idx     <= 1'b0;
        end else if (rx_byte[7]) begin
          status       <= rx_byte;
          status_valid <= 1'b1;
          data_idx     <= 1'b0;
        end else if (status_valid) begin
          if (one_data_byte(kind)) begin
            data_idx <= 1'b0;
          end else if (!data_idx) begin
            first_data <= rx_byte[6:0];
            data_idx   <= 1'b1;
          end else begin
            data_idx <= 1'b0;
            if (note_on_hit) begin
              note           <= first_data;
              velocity       <= rx_byte[6:0];
              gate           <= 1'b1;
              change_pending <= 1'b1;
            end else if (note_off_hit) begin
              gate <= 1'b0;
            end else begin
              gate <= gate;
            end
          end
        end else begin
          data_idx <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Self-checking bench: two decoders (channel 0, and OMNI) share one serial line;
// directed table steps, corner sequences and random bytes against a message model.
module tb_midi_note_decoder;

  localparam int BITC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic [6:0] note_a, vel_a, note_b, vel_b;
  logic gate_a, chg_a, ferr_a, gate_b, chg_b, ferr_b;

  midi_note_decoder #(.CLK_HZ(500000), .BAUD(31250), .CHANNEL(0), .OMNI(0)) dut_a (
    .CLK24M(clk), .RST(rst), .midi_rx(rx), .note(note_a), .velocity(vel_a),
    .gate(gate_a), .changeCLK(chg_a), .framing_err(ferr_a));

  midi_note_decoder #(.CLK_HZ(500000), .BAUD(31250), .CHANNEL(5), .OMNI(1)) dut_b (
    .CLK24M(clk), .RST(rst), .midi_rx(rx), .note(note_b), .velocity(vel_b),
    .gate(gate_b), .changeCLK(chg_b), .framing_err(ferr_b));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses_a = 0, pulses_b = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
  logic prev_chg_a = 1'b0, prev_chg_b = 1'b0;

  // Reference model state per decoder (0: channel 0 only, 1: omni).
  int m_note[2], m_vel[2], m_gate[2], m_pulses[2], m_status[2], m_len[2];
  int m_d[2][2];

  typedef struct {
    int               n;
    logic [0:3][7:0]  b;
    int               note;
    int               vel;
    int               gate;
    int               pulses;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse counting, no back-to-back strobes, nothing pulses during reset.
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if (chg_a || chg_b || ferr_a || ferr_b) begin
        miscompares++;
        $display("FAIL reset_quiet: chg=%b%b ferr=%b%b, expected all 0", chg_a, chg_b, ferr_a, ferr_b);
      end
    end else begin
      if (chg_a) begin
        pulses_a++;
        check("chg_a_spacing", int'(prev_chg_a), 0);
      end
      if (chg_b) begin
        pulses_b++;
        check("chg_b_spacing", int'(prev_chg_b), 0);
      end
      if (ferr_a) ferr_cnt_a++;
      if (ferr_b) ferr_cnt_b++;
    end
    prev_chg_a = chg_a;
    prev_chg_b = chg_b;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_note[k] = 0; m_vel[k] = 0; m_gate[k] = 0;
      m_status[k] = -1; m_len[k] = 0;
    end
  endtask

  task automatic model_byte(input int b);
    int kind, need;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      if (b >= 'hF8) continue;
      if (b >= 'hF0) begin
        m_status[k] = -1; m_len[k] = 0;
      end else if (b >= 'h80) begin
        m_status[k] = b; m_len[k] = 0;
      end else if (m_status[k] >= 0) begin
        m_d[k][m_len[k]] = b;
        m_len[k]++;
        kind = m_status[k] / 16;
        need = (kind == 12 || kind == 13) ? 1 : 2;
        if (m_len[k] == need) begin
          ok = (k == 1) || ((m_status[k] % 16) == 0);
          if (ok && kind == 9 && m_d[k][1] > 0) begin
            m_note[k] = m_d[k][0]; m_vel[k] = m_d[k][1]; m_gate[k] = 1; m_pulses[k]++;
          end else if (ok && (kind == 8 || kind == 9) && m_d[k][0] == m_note[k] && m_gate[k] == 1) begin
            m_gate[k] = 0;
          end
          m_len[k] = 0;
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BITC);
    end
    rx = stop_bit;
    wait_cycles(BITC);
    rx = 1'b1;
  endtask

  task automatic send_msg(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(int'(b));
    wait_cycles(6);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " a.note"}, note_a, m_note[0]);
    check({tag, " a.vel"}, vel_a, m_vel[0]);
    check({tag, " a.gate"}, gate_a, m_gate[0]);
    check({tag, " a.pulses"}, pulses_a, m_pulses[0]);
    check({tag, " b.note"}, note_b, m_note[1]);
    check({tag, " b.vel"}, vel_b, m_vel[1]);
    check({tag, " b.gate"}, gate_b, m_gate[1]);
    check({tag, " b.pulses"}, pulses_b, m_pulses[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " note"}, note_a, 0);
    check({tag, " velocity"}, vel_a, 0);
    check({tag, " gate"}, gate_a, 0);
    check({tag, " changeCLK"}, chg_a, 0);
    check({tag, " framing_err"}, ferr_a, 0);
    check({tag, " b.note"}, note_b, 0);
    check({tag, " b.gate"}, gate_b, 0);
  endtask

  task automatic watch_first_note();
    int t;
    t = 0;
    while (note_a != 7'd60 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      check("first_note_timeout", note_a, 60);
    end else begin
      check("first chg before update", chg_a, 0);
      @(negedge clk);
      check("first chg pulse", chg_a, 1);
      check("first velocity", vel_a, 100);
      check("first gate", gate_a, 1);
      @(negedge clk);
      check("first chg after", chg_a, 0);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] ch;
    r  = $urandom_range(0, 99);
    ch = 4'($urandom_range(0, 2) * 5);
    if (r < 12) return {4'h9, ch};
    if (r < 20) return {4'h8, ch};
    if (r < 24) return ($urandom_range(0, 1) == 0) ? {4'hC, ch} : {4'hD, ch};
    if (r < 27) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 29) return 8'($urandom_range(8'hF0, 8'hF7));
    if (r < 40) return 8'h00;
    if (r < 75) return 8'($urandom_range(60, 63));
    return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    int p0, f0a, f0b;
    logic [7:0] b;
    for (int k = 0; k < 2; k++) m_pulses[k] = 0;
    model_reset();

    tbl[0] = '{2, {8'h40, 8'h50, 8'h00, 8'h00}, 64, 80, 1, 1};
    tbl[1] = '{2, {8'h3C, 8'h00, 8'h00, 8'h00}, 64, 80, 1, 0};
    tbl[2] = '{2, {8'h40, 8'h00, 8'h00, 8'h00}, 64, 80, 0, 0};
    tbl[3] = '{4, {8'h90, 8'hF8, 8'h45, 8'h7F}, 69, 127, 1, 1};
    tbl[4] = '{4, {8'h90, 8'hF0, 8'h45, 8'h7F}, 69, 127, 1, 0};
    tbl[5] = '{3, {8'h91, 8'h30, 8'h40, 8'h00}, 69, 127, 1, 0};
    tbl[6] = '{4, {8'hC0, 8'h05, 8'h3C, 8'h10}, 69, 127, 1, 0};
    tbl[7] = '{3, {8'h90, 8'h45, 8'h10, 8'h00}, 69, 16, 1, 1};
    tbl[8] = '{2, {8'h45, 8'h20, 8'h00, 8'h00}, 69, 32, 1, 1};
    tbl[9] = '{3, {8'h80, 8'h45, 8'h7F, 8'h00}, 69, 32, 0, 0};

    wait_cycles(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(2 * BITC + 4);

    // First note-on with cycle-level strobe timing.
    send_msg(8'h90);
    send_msg(8'h3C);
    fork
      send_byte(8'h64, 1'b1);
      watch_first_note();
    join
    model_byte(8'h64);
    wait_cycles(6);
    cmp_model("first");

    for (int i = 0; i < 10; i++) begin
      p0 = pulses_a;
      for (int j = 0; j < tbl[i].n; j++) send_msg(tbl[i].b[j]);
      wait_cycles(4);
      check($sformatf("step%0d note", i), note_a, tbl[i].note);
      check($sformatf("step%0d velocity", i), vel_a, tbl[i].vel);
      check($sformatf("step%0d gate", i), gate_a, tbl[i].gate);
      check($sformatf("step%0d pulses", i), pulses_a - p0, tbl[i].pulses);
      cmp_model($sformatf("step%0d", i));
    end
    check("omni repeat note-off leaves b", note_b, 69);

    // Bad stop bit: exactly one error cycle, byte discarded.
    f0a = ferr_cnt_a;
    f0b = ferr_cnt_b;
    send_byte(8'h90, 1'b0);
    wait_cycles(2 * BITC + 4);
    check("framing_err a pulses", ferr_cnt_a - f0a, 1);
    check("framing_err b pulses", ferr_cnt_b - f0b, 1);
    cmp_model("framing");

    // One-cycle glitch on idle line: no byte, no error, next message intact.
    f0a = ferr_cnt_a;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    wait_cycles(2 * BITC + 4);
    check("glitch framing_err", ferr_cnt_a - f0a, 0);
    send_msg(8'h90);
    send_msg(8'h41);
    send_msg(8'h33);
    cmp_model("glitch");

    for (int i = 0; i < 150; i++) begin
      b = rand_byte();
      send_msg(b);
      wait_cycles($urandom_range(0, 24));
      cmp_model($sformatf("rand%0d(%02h)", i, b));
    end

    // Reset during the 4th data bit of a note-on.
    send_msg(8'h90);
    send_msg(8'h3E);
    send_msg(8'h22);
    cmp_model("pre_reset");
    send_msg(8'h90);
    b = 8'h3C;
    rx = 1'b0;
    wait_cycles(BITC);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_cycles(BITC);
    end
    rx = b[3];
    wait_cycles(BITC / 2);
    rst = 1'b1;
    wait_cycles(3);
    check_reset_outputs("mid_byte_reset");
    rx = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    model_reset();
    wait_cycles(1);
    check_reset_outputs("after_reset");
    wait_cycles(2 * BITC + 4);
    send_msg(8'h90);
    send_msg(8'h3C);
    send_msg(8'h64);
    check("post_reset note", note_a, 60);
    check("post_reset velocity", vel_a, 100);
    check("post_reset gate", gate_a, 1);
    cmp_model("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
